data_mem_responder: RTL and testbench

// - Memory-side responder for the processor's 16-bit data-memory bus
//   (processor drives address/write data/command, this block returns read data).
// - Holds the operand/result matrices of the single-core multiplier in an

---
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the processor's 16-bit data-memory bus. Holds the
// multiplier's operand/result words in an internal array and answers each
// request after a fixed number of cycles. Only one request may be in flight;
// both the request and the response use a valid/ready handshake.

module data_mem_responder #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // The counter is loaded with LATENCY-1 on accept, so the access lands
   // exactly LATENCY edges after the accept edge.
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   // The address is compared one bit wider so DEPTH == 2**ADDR_W still works.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   // The array index only needs enough bits to cover DEPTH words; it is used
   // only when the address is already known to be in range.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [3:0]        cnt;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              access;
   logic              consume;
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   assign accept   = (state == ST_IDLE) && req_valid && req_ready;
   assign access   = (state == ST_WAIT) && (cnt == 4'd0);
   assign consume  = (state == ST_RESP) && rsp_valid && rsp_ready;
   assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
   assign idx      = addr_q[IDX_W-1:0];

   // Next-state selection for the IDLE -> WAIT -> RESP -> IDLE cycle
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept)       state_next = ST_WAIT;
         ST_WAIT: if (cnt == 4'd0)  state_next = ST_RESP;
         ST_RESP: if (consume)      state_next = ST_IDLE;
         default:                   state_next = ST_IDLE;
      endcase
   end

   // Control state, request capture, latency counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b0;
         cnt       <= 4'd0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_next;
         req_ready <= (state_next == ST_IDLE);

         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_INIT;
         end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end

         if (access) begin
            rsp_valid <= 1'b1;
            if (in_range) begin
               rsp_err   <= 1'b0;
               rsp_rdata <= wr_q ? wdata_q : mem[idx];
            end else begin
               rsp_err   <= 1'b1;
               rsp_rdata <= '0;
            end
         end else if (consume) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Array write, committed on the WAIT -> RESP edge; the array is never reset
   always_ff @(posedge clk) begin
      if (access && wr_q && in_range) begin
         mem[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Four responder instances share clock and reset: [0] DEPTH=256/LATENCY=2,
// [1] DEPTH=200/LATENCY=2, [2] LATENCY=1, [3] LATENCY=15. Expected responses
// are queued when a request is driven and popped when the response appears.

module tb_data_mem_responder;

   localparam int NDUT = 4;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      int          dut;
      bit          wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      bit          err;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid [NDUT];
   logic        req_ready [NDUT];
   logic        req_write [NDUT];
   logic [7:0]  req_addr  [NDUT];
   logic [15:0] req_wdata [NDUT];
   logic        rsp_valid [NDUT];
   logic        rsp_ready [NDUT];
   logic [15:0] rsp_rdata [NDUT];
   logic        rsp_err   [NDUT];

   exp_t        sb [$];
   int          n_vec;
   int          n_miss;
   logic [15:0] model   [256];
   bit          written [256];

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      data_mem_responder #(
         .DATA_W  (16),
         .ADDR_W  (8),
         .DEPTH   ((g == 1) ? 200 : 256),
         .LATENCY ((g == 2) ? 1 : (g == 3) ? 15 : 2)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 2) ? 1 : (d == 3) ? 15 : 2;
   endfunction

   task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL dut%0d %s: got %h, expected %h", d, name, act, exp);
      end
   endtask

   // Waits for req_ready, drives one request, queues its expected response and
   // leaves the time just after the accept edge with scrambled request inputs.
   task automatic applyStimulus(input int d, input bit wr, input logic [7:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                input bit exp_err, output bit ok);
      exp_t e;
      int   n;
      ok = 1'b0;
      @(negedge clk);
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) begin
         check(d, "req_ready_timeout", 32'(req_ready[d]), 32'd1);
         return;
      end
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = lat_of(d);
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_write[d] = ~wr;
      req_addr[d]  = ~addr;
      req_wdata[d] = ~wdata;
      ok = 1'b1;
   endtask

   // Measures latency, compares the response against the queue, optionally
   // holds off rsp_ready while pulsing req_valid, then consumes the response.
   task automatic checkOutput(input int d, input int hold);
      exp_t e;
      int   lat;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid[d]) begin
            lat = i;
            break;
         end
      end
      if (sb.size() == 0) begin
         check(d, "scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check(d, "latency", 32'(lat), 32'(e.lat));
      if (lat == 0) return;
      check(d, "rsp_rdata", 32'(rsp_rdata[d]), 32'(e.rdata));
      check(d, "rsp_err", 32'(rsp_err[d]), 32'(e.err));
      for (int k = 0; k < hold; k++) begin
         req_valid[d] = 1'b1;
         req_write[d] = 1'b0;
         req_addr[d]  = 8'h33;
         check(d, "hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
         check(d, "hold_rsp_rdata", 32'(rsp_rdata[d]), 32'(e.rdata));
         check(d, "hold_req_ready", 32'(req_ready[d]), 32'd0);
         @(posedge clk);
         #1;
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
      check(d, "done_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check(d, "done_req_ready", 32'(req_ready[d]), 32'd1);
      check(d, "done_rsp_err", 32'(rsp_err[d]), 32'd0);
      check(d, "done_rdata_hold", 32'(rsp_rdata[d]), 32'(e.rdata));
   endtask

   task automatic runTxn(input int d, input bit wr, input logic [7:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata, input bit exp_err);
      bit ok;
      applyStimulus(d, wr, addr, wdata, exp_rdata, exp_err, ok);
      if (ok) checkOutput(d, 0);
   endtask

   initial begin
      vec_t        vecs [13];
      bit          ok;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] w;

      n_vec  = 0;
      n_miss = 0;
      vecs = '{
         '{0, 1'b1, 8'h12, 16'hBEEF, 16'hBEEF, 1'b0},
         '{0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b0},
         '{0, 1'b1, 8'h05, 16'h5555, 16'h5555, 1'b0},
         '{0, 1'b0, 8'h05, 16'hFFFF, 16'h5555, 1'b0},
         '{0, 1'b1, 8'hFF, 16'h7E7E, 16'h7E7E, 1'b0},
         '{0, 1'b0, 8'hFF, 16'h0000, 16'h7E7E, 1'b0},
         '{1, 1'b1, 8'd200, 16'h1234, 16'h0000, 1'b1},
         '{1, 1'b0, 8'd200, 16'h0000, 16'h0000, 1'b1},
         '{1, 1'b1, 8'd199, 16'h0001, 16'h0001, 1'b0},
         '{1, 1'b0, 8'd199, 16'h0000, 16'h0001, 1'b0},
         '{1, 1'b1, 8'd255, 16'hFFFF, 16'h0000, 1'b1},
         '{1, 1'b1, 8'd0,   16'hA5A5, 16'hA5A5, 1'b0},
         '{1, 1'b0, 8'd0,   16'h0000, 16'hA5A5, 1'b0}
      };

      for (int d = 0; d < NDUT; d++) begin
         req_valid[d] = 1'b0;
         req_write[d] = 1'b0;
         req_addr[d]  = 8'h00;
         req_wdata[d] = 16'h0000;
         rsp_ready[d] = 1'b0;
      end

      // Reset held three cycles, then released between edges
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) begin
            check(d, "rst_req_ready", 32'(req_ready[d]), 32'd0);
            check(d, "rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check(d, "rst_rsp_rdata", 32'(rsp_rdata[d]), 32'd0);
            check(d, "rst_rsp_err", 32'(rsp_err[d]), 32'd0);
         end
      end
      rst_n = 1'b1;
      #1;
      check(0, "release_req_ready_low", 32'(req_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      check(0, "release_req_ready_high", 32'(req_ready[0]), 32'd1);

      // Table of single transactions
      for (int i = 0; i < 13; i++) begin
         runTxn(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
      end

      // Backpressure: response held five cycles while req_valid is pulsed
      applyStimulus(0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 1'b0, ok);
      if (ok) checkOutput(0, 5);
      repeat (5) begin
         @(posedge clk);
         #1;
         check(0, "no_stray_accept", 32'(rsp_valid[0]), 32'd0);
      end

      // Reset during WAIT of a write: the write is lost
      applyStimulus(0, 1'b1, 8'h05, 16'hAAAA, 16'hAAAA, 1'b0, ok);
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check(0, "midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check(0, "midrst_req_ready", 32'(req_ready[0]), 32'd0);
      check(0, "midrst_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runTxn(0, 1'b0, 8'h05, 16'h0000, 16'h5555, 1'b0);

      // Random write/read pairs on the LATENCY=1 and LATENCY=15 builds
      for (int d = 2; d < NDUT; d++) begin
         for (int j = 0; j < 256; j++) written[j] = 1'b0;
         for (int p = 0; p < 64; p++) begin
            a = 8'($urandom_range(0, 255));
            w = 16'($urandom);
            model[a]   = w;
            written[a] = 1'b1;
            runTxn(d, 1'b1, a, w, w, 1'b0);
            b = 8'($urandom_range(0, 255));
            if (!written[b]) b = a;
            runTxn(d, 1'b0, b, 16'h0000, model[b], 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
